inst_dec: RTL and testbench

Instruction decoder for the 16-bit RISC core. It splits a 16-bit instruction word into an ALU operation code, three 4-bit register-file selects, a 16-bit immediate and a register write enable. All outputs are registered and update only when enabled. It sits between the fetch stage (instruction register) and the register file / ALU.

---
 rtl/isa_pkg.sv | 57 +++++
 rtl/inst_dec_comb.sv | 61 ++++++
 rtl/inst_dec.sv | 59 +++++
 tb/tb_inst_dec.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// ============================================================================
// Module  : isa_pkg
// Purpose : Shared ISA definitions for the 16-bit RISC core. Holds the opcode
//           constants, the instruction field bit positions, the immediate-form
//           flag index, and the decoded-instruction bundle type.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package isa_pkg;

  // Opcode values, taken from inst[15:12]
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_NOT  = 4'h5;
  localparam logic [3:0] OP_SHL  = 4'h6;
  localparam logic [3:0] OP_SHR  = 4'h7;
  localparam logic [3:0] OP_ADDI = 4'h8;
  localparam logic [3:0] OP_LDI  = 4'h9;
  localparam logic [3:0] OP_LDH  = 4'hA;
  localparam logic [3:0] OP_CMP  = 4'hB;
  localparam logic [3:0] OP_LD   = 4'hC;
  localparam logic [3:0] OP_ST   = 4'hD;
  localparam logic [3:0] OP_BR   = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Instruction field bit positions
  localparam int OP_MSB = 15;
  localparam int OP_LSB = 12;
  localparam int RD_MSB = 11;
  localparam int RD_LSB = 8;
  localparam int RA_MSB = 7;
  localparam int RA_LSB = 4;
  localparam int RB_MSB = 3;
  localparam int RB_LSB = 0;

  // Bit of the ALU op code flagging the immediate forms
  localparam int IMM_FORM = 4;

  // Full decoded-instruction bundle, registered as one unit so that every
  // output changes on the same edge.
  typedef struct packed {
    logic [4:0]  aluop;
    logic [3:0]  selA;
    logic [3:0]  selB;
    logic [3:0]  selD;
    logic [15:0] imm;
    logic        regwe;
  } dec_t;

endpackage : isa_pkg

`default_nettype wire

// File: rtl/inst_dec_comb.sv
// ============================================================================
// Module  : inst_dec_comb
// Purpose : Purely combinational decode of a 16-bit instruction word into the
//           ALU op code, register selects, immediate and write enable.
// Ports   : i_inst [15:0] - instruction word
//           o_dec  dec_t  - decoded fields (next-state for the output register)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_dec_comb
  import isa_pkg::*;
(
  input  logic [15:0] i_inst,
  output dec_t        o_dec
);

  logic [3:0] w_opcode;

  assign w_opcode = i_inst[OP_MSB:OP_LSB];

  always_comb begin
    o_dec            = '0;
    o_dec.selD       = i_inst[RD_MSB:RD_LSB];
    o_dec.selA       = i_inst[RA_MSB:RA_LSB];
    o_dec.selB       = i_inst[RB_MSB:RB_LSB];
    o_dec.aluop[3:0] = w_opcode;
    o_dec.regwe      = 1'b1;

    case (w_opcode)
      OP_ADDI: begin
        o_dec.aluop[IMM_FORM] = 1'b1;
        o_dec.imm             = {{12{i_inst[3]}}, i_inst[3:0]};
      end
      OP_LDI: begin
        o_dec.aluop[IMM_FORM] = 1'b1;
        o_dec.imm             = {8'h00, i_inst[7:0]};
      end
      OP_LDH: begin
        o_dec.aluop[IMM_FORM] = 1'b1;
        o_dec.imm             = {i_inst[7:0], 8'h00};
      end
      OP_ST: begin
        o_dec.regwe = 1'b0;
      end
      OP_BR: begin
        // Branch offset: immediate form with no register write-back
        o_dec.aluop[IMM_FORM] = 1'b1;
        o_dec.imm             = {{4{i_inst[11]}}, i_inst[11:0]};
        o_dec.regwe           = 1'b0;
      end
      OP_HALT: begin
        o_dec.regwe = 1'b0;
      end
      default: ;
    endcase
  end

endmodule : inst_dec_comb

`default_nettype wire

// File: rtl/inst_dec.sv
// ============================================================================
// Module  : inst_dec
// Purpose : Registered instruction decoder. Wraps inst_dec_comb with an
//           enable-gated, asynchronously reset output register.
// Ports   : i_clk    - clock, rising edge
//           i_rst_n  - asynchronous active-low reset
//           i_en     - decode enable (outputs load only when 1)
//           i_inst   - 16-bit instruction word
//           o_aluop  - {imm_form, opcode}
//           o_selA   - register read port A select
//           o_selB   - register read port B select
//           o_selD   - register destination select
//           o_imm    - decoded immediate
//           o_regwe  - register write enable
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_dec
  import isa_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_en,
  input  logic [15:0] i_inst,
  output logic [4:0]  o_aluop,
  output logic [3:0]  o_selA,
  output logic [3:0]  o_selB,
  output logic [3:0]  o_selD,
  output logic [15:0] o_imm,
  output logic        o_regwe
);

  dec_t dec_d;
  dec_t dec_q;

  inst_dec_comb u_comb (
    .i_inst (i_inst),
    .o_dec  (dec_d)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dec_q <= '0;
    end else if (i_en) begin
      dec_q <= dec_d;
    end
  end

  assign o_aluop = dec_q.aluop;
  assign o_selA  = dec_q.selA;
  assign o_selB  = dec_q.selB;
  assign o_selD  = dec_q.selD;
  assign o_imm   = dec_q.imm;
  assign o_regwe = dec_q.regwe;

endmodule : inst_dec

`default_nettype wire

// File: tb/tb_inst_dec.sv
// ============================================================================
// Module  : tb_inst_dec
// Purpose : Self-checking bench for inst_dec. Expected values come from
//           constants and an ISA-level reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_dec;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] inst;
  logic [4:0]  aluop;
  logic [3:0]  selA, selB, selD;
  logic [15:0] imm;
  logic        regwe;

  int n_checks;
  int n_fail;

  // {aluop, selD, selA, selB, imm, regwe}
  logic [33:0] obs;
  assign obs = {aluop, selD, selA, selB, imm, regwe};

  inst_dec dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_en    (en),
    .i_inst  (inst),
    .o_aluop (aluop),
    .o_selA  (selA),
    .o_selB  (selB),
    .o_selD  (selD),
    .o_imm   (imm),
    .o_regwe (regwe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ISA-level reference: what the instruction means, computed arithmetically.
  function automatic logic [33:0] model(input logic [15:0] w);
    int op, rd, ra, rb, v;
    logic is_imm, we;
    logic [15:0] im;
    op = int'(w) / 4096;
    rd = (int'(w) / 256) % 16;
    ra = (int'(w) / 16) % 16;
    rb = int'(w) % 16;
    is_imm = (op == 8) || (op == 9) || (op == 10) || (op == 14);
    we = (op < 13);
    im = 16'h0000;
    if (op == 8) begin
      v = rb; if (v >= 8) v = v - 16;          // signed 4-bit
      im = 16'(v);
    end else if (op == 9) begin
      im = 16'(int'(w) % 256);
    end else if (op == 10) begin
      im = 16'((int'(w) % 256) * 256);
    end else if (op == 14) begin
      v = int'(w) % 4096; if (v >= 2048) v = v - 4096;   // signed 12-bit
      im = 16'(v);
    end
    return {is_imm, 4'(op), 4'(rd), 4'(ra), 4'(rb), im, we};
  endfunction

  // Drive inputs at a falling edge, then advance to the next falling edge
  // (one rising edge in between) so outputs can be sampled.
  task automatic step(input logic e, input logic [15:0] w);
    en = e;
    inst = w;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    en = 1'b1;
    inst = 16'hFFFF;
    #1;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (obs !== 34'h0) begin
      n_fail++;
      $display("FAIL reset_held: got %h expected %h", obs, 34'h0);
    end
    en = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (obs !== 34'h0) begin
      n_fail++;
      $display("FAIL reset_release: got %h expected %h", obs, 34'h0);
    end
  endtask

  task automatic test_enable;
    logic [33:0] exp;
    step(1'b0, 16'h1704);
    step(1'b0, 16'h1704);
    n_checks++;
    if (obs !== 34'h0) begin
      n_fail++;
      $display("FAIL enable_gated: got %h expected %h", obs, 34'h0);
    end
    step(1'b1, 16'h1704);
    exp = {5'b00001, 4'd7, 4'd0, 4'd4, 16'h0000, 1'b1};
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL enable_load: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_hold;
    logic [33:0] exp;
    exp = {5'b00001, 4'd7, 4'd0, 4'd4, 16'h0000, 1'b1};
    step(1'b0, 16'hD123);
    step(1'b0, 16'hD123);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL hold: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_immediates;
    logic [15:0] ins  [4];
    logic [33:0] exps [4];
    ins[0] = 16'h832F; exps[0] = {5'b11000, 4'h3, 4'h2, 4'hF, 16'hFFFF, 1'b1};
    ins[1] = 16'h95A7; exps[1] = {5'b11001, 4'h5, 4'hA, 4'h7, 16'h00A7, 1'b1};
    ins[2] = 16'hA5A7; exps[2] = {5'b11010, 4'h5, 4'hA, 4'h7, 16'hA700, 1'b1};
    ins[3] = 16'hE800; exps[3] = {5'b11110, 4'h8, 4'h0, 4'h0, 16'hF800, 1'b0};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, ins[i]);
      n_checks++;
      if (obs !== exps[i]) begin
        n_fail++;
        $display("FAIL imm_%h: got %h expected %h", ins[i], obs, exps[i]);
      end
    end
  endtask

  task automatic test_regwe_sweep;
    logic [15:0] w;
    logic        exp_we;
    for (int op = 0; op < 16; op++) begin
      w = {4'(op), 4'h1, 4'h2, 4'h3};
      exp_we = (op != 13) && (op != 14) && (op != 15);
      step(1'b1, w);
      n_checks++;
      if (regwe !== exp_we || selD !== 4'h1 || selA !== 4'h2 || selB !== 4'h3) begin
        n_fail++;
        $display("FAIL sweep_op%0d: got regwe=%b sel=%h/%h/%h expected regwe=%b sel=1/2/3",
                 op, regwe, selD, selA, selB, exp_we);
      end
      n_checks++;
      if (obs !== model(w)) begin
        n_fail++;
        $display("FAIL sweep_full_op%0d: got %h expected %h", op, obs, model(w));
      end
    end
  endtask

  task automatic test_random;
    logic [33:0] ref_q;
    logic        e;
    logic [15:0] w;
    ref_q = obs === model(16'hF123) ? 34'h0 : 34'h0;
    // Start from a known loaded state
    step(1'b1, 16'h0000);
    ref_q = model(16'h0000);
    for (int i = 0; i < 300; i++) begin
      e = ($urandom_range(0, 3) != 0);
      w = 16'($urandom);
      step(e, w);
      if (e) ref_q = model(w);
      n_checks++;
      if (obs !== ref_q) begin
        n_fail++;
        $display("FAIL random_%0d: inst=%h en=%b got %h expected %h", i, w, e, obs, ref_q);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] w;
    // Consecutive enabled loads: every edge takes the new word
    for (int i = 0; i < 20; i++) begin
      w = 16'($urandom);
      step(1'b1, w);
      n_checks++;
      if (obs !== model(w)) begin
        n_fail++;
        $display("FAIL back_to_back_%0d: inst=%h got %h expected %h", i, w, obs, model(w));
      end
    end
  endtask

  task automatic test_async_reset;
    step(1'b1, 16'h9CFF);
    n_checks++;
    if (obs !== model(16'h9CFF) || obs === 34'h0) begin
      n_fail++;
      $display("FAIL pre_async_load: got %h expected %h", obs, model(16'h9CFF));
    end
    // Mid-cycle reset pulse, sampled well before the next rising edge
    en = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== 34'h0) begin
      n_fail++;
      $display("FAIL async_reset: got %h expected %h", obs, 34'h0);
    end
    #1 rst_n = 1'b1;
    @(negedge clk);
    // First enabled edge after release loads again
    n_checks++;
    if (obs !== model(16'h9CFF)) begin
      n_fail++;
      $display("FAIL post_reset_load: got %h expected %h", obs, model(16'h9CFF));
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    en       = 1'b0;
    inst     = 16'h0000;
    test_reset();
    test_enable();
    test_hold();
    test_immediates();
    test_regwe_sweep();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_inst_dec

`default_nettype wire
